fft_twiddle_streamer: RTL



---
 rtl/fft_twiddle_pkg.sv | 44 ++++
 rtl/fft_twiddle_addr_gen.sv | 34 +++
 rtl/fft_twiddle_streamer.sv | 113 +++++++++++
 3 files changed

// File: rtl/fft_twiddle_pkg.sv
// ---------------------------------------------------------------------------
// fft_twiddle_pkg
// Shared types and helpers for the FFT twiddle streamer.
//   state_t         : streamer FSM states (IDLE, STREAM)
//   DEFAULT_*       : default table geometry (N = 128, 32-bit entries, Q16)
//   fft_log2/half/quarter : derive LOG2 / HALF / QUARTER from an FFT length
//   twiddle_index   : table index k of butterfly j in radix-2 stage s
// ---------------------------------------------------------------------------
package fft_twiddle_pkg;

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   localparam int DEFAULT_SIZE_FFT      = 128;
   localparam int DEFAULT_BIT_WIDTH     = 32;
   localparam int DEFAULT_DECIMAL_POINT = 16;

   function automatic int fft_log2(input int size_fft);
      return $clog2(size_fft);
   endfunction

   function automatic int fft_half(input int size_fft);
      return size_fft / 2;
   endfunction

   function automatic int fft_quarter(input int size_fft);
      return size_fft / 4;
   endfunction

   // Stage s has 2^s distinct twiddles, repeating every 2^s butterflies, spaced
   // N/2^(s+1) table entries apart. The result is always below N/2.
   function automatic int unsigned twiddle_index(input int unsigned stage,
                                                 input int unsigned j,
                                                 input int unsigned size_fft);
      int unsigned mask;
      int unsigned stride;
      mask   = (32'd1 << stage) - 32'd1;
      stride = size_fft >> (stage + 32'd1);
      return (j & mask) * stride;
   endfunction

endpackage

// File: rtl/fft_twiddle_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_twiddle_addr_gen
// Combinational address generator: maps (stage, butterfly j) to the two sine
// table addresses that hold cos(2*pi*k/N) and -sin(2*pi*k/N).
//   stage     in  : radix-2 stage index (already saturated to LOG2-1)
//   j         in  : butterfly index within the stage, 0 .. N/2-1
//   cos_addr  out : (k + N/4) mod N
//   msin_addr out : (k + N/2) mod N
// ---------------------------------------------------------------------------
module fft_twiddle_addr_gen
   import fft_twiddle_pkg::*;
#(
   parameter  int SIZE_FFT = DEFAULT_SIZE_FFT,
   localparam int LOG2     = fft_log2(SIZE_FFT)
) (
   input  logic [LOG2-1:0] stage,
   input  logic [LOG2-2:0] j,
   output logic [LOG2-1:0] cos_addr,
   output logic [LOG2-1:0] msin_addr
);

   localparam int HALF    = fft_half(SIZE_FFT);
   localparam int QUARTER = fft_quarter(SIZE_FFT);

   logic [LOG2-1:0] k;

   assign k = LOG2'(twiddle_index(32'(stage), 32'(j), 32'(SIZE_FFT)));

   // Phase shifts by a quarter / half turn; the LOG2-bit sum wraps modulo N,
   // and the table itself supplies the sign, so no negation is needed.
   assign cos_addr  = k + LOG2'(QUARTER);
   assign msin_addr = k + LOG2'(HALF);

endmodule

// File: rtl/fft_twiddle_streamer.sv
// ---------------------------------------------------------------------------
// fft_twiddle_streamer
// On a stage request, streams the N/2 twiddle factors W = cos - j*sin of that
// radix-2 stage in butterfly order, read from a fixed-point sine table.
//   clk, reset    : clock, asynchronous active-high reset
//   sine_wave_in  : sine table, entry i = sin(2*pi*i/N) * 2^DECIMAL_POINT
//   recv_msg/val/rdy : stage request stream (out-of-range stages saturate)
//   send_msg/val/rdy : twiddle stream, send_msg = {real, imag}
//   send_last     : marks the final twiddle of the stage
// All outputs come from registers or the table; no input-to-output paths.
// ---------------------------------------------------------------------------
module fft_twiddle_streamer
   import fft_twiddle_pkg::*;
#(
   parameter int BIT_WIDTH     = DEFAULT_BIT_WIDTH,
   parameter int DECIMAL_POINT = DEFAULT_DECIMAL_POINT,
   parameter int SIZE_FFT      = DEFAULT_SIZE_FFT
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic signed [BIT_WIDTH-1:0] sine_wave_in [0:SIZE_FFT-1],
   input  logic [$clog2(SIZE_FFT)-1:0] recv_msg,
   input  logic                        recv_val,
   output logic                        recv_rdy,
   output logic [2*BIT_WIDTH-1:0]      send_msg,
   output logic                        send_val,
   input  logic                        send_rdy,
   output logic                        send_last
);

   localparam int LOG2 = fft_log2(SIZE_FFT);
   localparam int HALF = fft_half(SIZE_FFT);

   localparam logic [LOG2-1:0] LAST_STAGE = LOG2'(LOG2 - 1);
   localparam logic [LOG2-2:0] J_LAST     = (LOG2 - 1)'(HALF - 1);
   localparam logic [LOG2-2:0] J_PRELAST  = (LOG2 - 1)'(HALF - 2);

   // Elaboration-time guards on the table geometry.
   if (SIZE_FFT < 4 || (SIZE_FFT & (SIZE_FFT - 1)) != 0) begin : g_bad_size
      $error("SIZE_FFT must be a power of two and at least 4");
   end
   if (DECIMAL_POINT >= BIT_WIDTH) begin : g_bad_point
      $error("DECIMAL_POINT must be smaller than BIT_WIDTH");
   end

   state_t          state;
   logic [LOG2-1:0] stage_r;
   logic [LOG2-2:0] j_r;
   logic [LOG2-1:0] cos_addr;
   logic [LOG2-1:0] msin_addr;

   // Handshake outputs are registered alongside the state so they follow the
   // same decode without a combinational output path.
   // NOTE: every register here uses non-blocking assignment so all flops
   // update together from the pre-edge values; blocking would create
   // order-dependent updates within the block.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         stage_r   <= '0;
         j_r       <= '0;
         recv_rdy  <= 1'b1;
         send_val  <= 1'b0;
         send_last <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (recv_val) begin
                  stage_r   <= (recv_msg > LAST_STAGE) ? LAST_STAGE : recv_msg;
                  j_r       <= '0;
                  state     <= STREAM;
                  recv_rdy  <= 1'b0;
                  send_val  <= 1'b1;
                  send_last <= 1'b0;
               end
            end
            STREAM: begin
               // Without send_rdy nothing moves, so send_msg holds stable.
               if (send_rdy) begin
                  if (j_r == J_LAST) begin
                     state     <= IDLE;
                     recv_rdy  <= 1'b1;
                     send_val  <= 1'b0;
                     send_last <= 1'b0;
                  end else begin
                     j_r       <= j_r + 1'b1;
                     send_last <= (j_r == J_PRELAST);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               recv_rdy <= 1'b1;
               send_val <= 1'b0;
               send_last <= 1'b0;
            end
         endcase
      end
   end

   fft_twiddle_addr_gen #(
      .SIZE_FFT (SIZE_FFT)
   ) u_addr_gen (
      .stage     (stage_r),
      .j         (j_r),
      .cos_addr  (cos_addr),
      .msin_addr (msin_addr)
   );

   // Table reads are combinational; the table is treated as static.
   assign send_msg = {sine_wave_in[cos_addr], sine_wave_in[msin_addr]};

endmodule
